// File: rtl/ostream_pkg.sv
// Shared defaults and the stored entry layout for the output stream buffer.
// Entry tag bits (first/last) sit above the data word.
package ostream_pkg;

  localparam int OSTREAM_DATA_WIDTH = 64;
  localparam int OSTREAM_DEPTH      = 16;

  typedef struct packed {
    logic                          first;
    logic                          last;
    logic [OSTREAM_DATA_WIDTH-1:0] data;
  } ostream_entry_t;

  localparam int OSTREAM_TAG_BITS = $bits(ostream_entry_t) - OSTREAM_DATA_WIDTH;

endpackage

// File: rtl/sout_stream_buffer_if.sv
// Producer write port, consumer stream port and status flags of the stream buffer.
// master = the surrounding logic, slave = the buffer itself.
interface sout_stream_buffer_if #(
  parameter int DATA_WIDTH = ostream_pkg::OSTREAM_DATA_WIDTH
);

  logic                  sout_wr_en;
  logic [DATA_WIDTH-1:0] sout_wr_data;
  logic                  sout_wr_last;
  logic                  ostream_valid;
  logic [DATA_WIDTH-1:0] ostream_data;
  logic                  ostream_first;
  logic                  ostream_last;
  logic                  ostream_ready;
  logic                  sout_buff_full;
  logic                  sout_buff_empty;
  logic                  sout_overflow;

  modport master (
    output sout_wr_en, sout_wr_data, sout_wr_last, ostream_ready,
    input  ostream_valid, ostream_data, ostream_first, ostream_last,
    input  sout_buff_full, sout_buff_empty, sout_overflow
  );

  modport slave (
    input  sout_wr_en, sout_wr_data, sout_wr_last, ostream_ready,
    output ostream_valid, ostream_data, ostream_first, ostream_last,
    output sout_buff_full, sout_buff_empty, sout_overflow
  );

endinterface

// File: rtl/sout_fifo_mem.sv
// Register-array storage for the stream buffer: synchronous write, asynchronous read.
// No reset on the array; validity is tracked entirely by the pointers outside.
module sout_fifo_mem #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sout_stream_buffer.sv
// Packet-tagging stream FIFO with a single registered output stage; write-to-valid is 2 cycles.
// Full FIFO drops writes (sticky overflow); output holds stable while ready is low.
module sout_stream_buffer
  import ostream_pkg::*;
#(
  parameter int DATA_WIDTH = OSTREAM_DATA_WIDTH,
  parameter int DEPTH      = OSTREAM_DEPTH
) (
  input logic                ostream_clk,
  input logic                ostream_rst,
  sout_stream_buffer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = DATA_WIDTH + OSTREAM_TAG_BITS;

  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic                  xfer;
  logic                  first_pend;
  logic                  out_vld;
  logic                  out_first;
  logic                  out_last;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  overflow;
  logic [EW-1:0]         head;
  logic [EW-1:0]         wr_entry;

  // Pointers carry one extra lap bit so full and empty differ only in the MSB.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign xfer     = out_vld && bus.ostream_ready;
  assign pop      = !fifo_empty && (!out_vld || xfer);
  assign push     = bus.sout_wr_en && !fifo_full;
  assign wr_entry = {first_pend, bus.sout_wr_last, bus.sout_wr_data};

  sout_fifo_mem #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (ostream_clk),
    .wr_en   (push && !ostream_rst),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (head)
  );

  always_ff @(posedge ostream_clk) begin
    if (ostream_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      first_pend <= 1'b1;
      overflow   <= 1'b0;
      out_vld    <= 1'b0;
      out_first  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + (AW+1)'(1);
        first_pend <= bus.sout_wr_last;
      end
      // A dropped write leaves first_pend alone so the packet boundary is not lost.
      if (bus.sout_wr_en && fifo_full) begin
        overflow <= 1'b1;
      end
      if (pop) begin
        rd_ptr                          <= rd_ptr + (AW+1)'(1);
        out_vld                         <= 1'b1;
        {out_first, out_last, out_data} <= head;
      end else if (xfer) begin
        out_vld <= 1'b0;
      end
    end
  end

  assign bus.ostream_valid   = out_vld;
  assign bus.ostream_data    = out_data;
  assign bus.ostream_first   = out_first;
  assign bus.ostream_last    = out_last;
  assign bus.sout_buff_full  = fifo_full;
  assign bus.sout_buff_empty = fifo_empty && !out_vld;
  assign bus.sout_overflow   = overflow;

endmodule

// File: tb/tb_sout_stream_buffer.sv
// Randomised scoreboard bench for sout_stream_buffer against a queue-level reference model.
module tb_sout_stream_buffer;
  import ostream_pkg::*;

  localparam int DW    = OSTREAM_DATA_WIDTH;
  localparam int DEPTH = OSTREAM_DEPTH;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sout_stream_buffer_if #(.DATA_WIDTH(DW)) bus ();

  sout_stream_buffer #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .ostream_clk (clk),
    .ostream_rst (rst),
    .bus         (bus)
  );

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  // Reference model: words held in storage, plus one word occupying the output slot.
  ostream_entry_t m_fifo[$];
  ostream_entry_t exp_q[$];
  ostream_entry_t m_ent;
  logic           m_ov;
  logic           m_first_pend;
  logic           m_ovf;
  bit             m_full;
  bit             m_pop;
  bit             started = 0;
  int             xfer_cnt = 0;

  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      m_fifo.delete();
      exp_q.delete();
      m_ov         = 1'b0;
      m_first_pend = 1'b1;
      m_ovf        = 1'b0;
    end else begin
      m_full = (m_fifo.size() == DEPTH);
      m_pop  = (m_fifo.size() != 0) && (!m_ov || bus.ostream_ready);
      if (m_ov && bus.ostream_ready) m_ov = 1'b0;
      if (m_pop) begin
        void'(m_fifo.pop_front());
        m_ov = 1'b1;
      end
      if (bus.sout_wr_en) begin
        if (m_full) begin
          m_ovf = 1'b1;
        end else begin
          m_ent = '{first: m_first_pend, last: bus.sout_wr_last, data: bus.sout_wr_data};
          m_fifo.push_back(m_ent);
          exp_q.push_back(m_ent);
          m_first_pend = bus.sout_wr_last;
        end
      end
    end
  end

  // Monitor: status against the model every cycle, words against the scoreboard on transfer.
  ostream_entry_t got;
  ostream_entry_t want;
  ostream_entry_t held;
  bit             hold_vld = 0;

  always @(negedge clk) begin
    if (started) begin
      got = '{first: bus.ostream_first, last: bus.ostream_last, data: bus.ostream_data};
      chk("valid", bus.ostream_valid, m_ov);
      chk("full", bus.sout_buff_full, m_fifo.size() == DEPTH);
      chk("empty", bus.sout_buff_empty, (m_fifo.size() == 0) && !m_ov);
      chk("overflow", bus.sout_overflow, m_ovf);
      if (hold_vld && bus.ostream_valid) chk("stall_stable", got, held);
      hold_vld = bus.ostream_valid && !bus.ostream_ready;
      held     = got;
      if (bus.ostream_valid && bus.ostream_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %0h expected none", got);
        end else begin
          want = exp_q.pop_front();
          chk("word", got, want);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) begin
      bus.sout_wr_en   = 1'($urandom_range(0, 1));
      bus.sout_wr_data = {$urandom, $urandom};
      bus.sout_wr_last = 1'($urandom_range(0, 1));
      step();
    end
    rst            = 1'b0;
    bus.sout_wr_en = 1'b0;
    chk("rst_valid", bus.ostream_valid, 1'b0);
    chk("rst_data", bus.ostream_data, '0);
    chk("rst_first", bus.ostream_first, 1'b0);
    chk("rst_last", bus.ostream_last, 1'b0);
    chk("rst_full", bus.sout_buff_full, 1'b0);
    chk("rst_empty", bus.sout_buff_empty, 1'b1);
    chk("rst_overflow", bus.sout_overflow, 1'b0);
  endtask

  task automatic drain(input string name);
    bus.sout_wr_en    = 1'b0;
    bus.ostream_ready = 1'b1;
    for (int i = 0; i < 8 * DEPTH && exp_q.size() != 0; i++) step();
    chk(name, exp_q.size(), 0);
  endtask

  int cnt0;
  int sent;

  initial begin
    bus.sout_wr_en    = 1'b0;
    bus.sout_wr_data  = '0;
    bus.sout_wr_last  = 1'b0;
    bus.ostream_ready = 1'b0;
    do_reset();

    // Single word latency.
    bus.ostream_ready = 1'b1;
    bus.sout_wr_en    = 1'b1;
    bus.sout_wr_data  = 64'hA5A5;
    bus.sout_wr_last  = 1'b1;
    step();
    bus.sout_wr_en = 1'b0;
    chk("lat_n1_valid", bus.ostream_valid, 1'b0);
    step();
    chk("lat_n2_valid", bus.ostream_valid, 1'b1);
    chk("lat_n2_data", bus.ostream_data, 64'hA5A5);
    chk("lat_n2_first", bus.ostream_first, 1'b1);
    chk("lat_n2_last", bus.ostream_last, 1'b1);
    step();
    chk("single_empty", bus.sout_buff_empty, 1'b1);

    // Backpressure on a 3-word packet.
    bus.ostream_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      bus.sout_wr_en   = 1'b1;
      bus.sout_wr_data = DW'(i);
      bus.sout_wr_last = (i == 3);
      step();
    end
    bus.sout_wr_en = 1'b0;
    step();
    chk("bp_hold", bus.ostream_data, 64'h1);
    step();
    bus.ostream_ready = 1'b1;
    chk("bp_w1", {bus.ostream_valid, bus.ostream_first, bus.ostream_last, bus.ostream_data}, {3'b110, 64'h1});
    step();
    chk("bp_w2", {bus.ostream_valid, bus.ostream_first, bus.ostream_last, bus.ostream_data}, {3'b100, 64'h2});
    step();
    chk("bp_w3", {bus.ostream_valid, bus.ostream_first, bus.ostream_last, bus.ostream_data}, {3'b101, 64'h3});
    step();
    chk("bp_done", bus.ostream_valid, 1'b0);

    // Fill past capacity with the consumer stalled.
    bus.ostream_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      bus.sout_wr_en   = 1'b1;
      bus.sout_wr_data = {$urandom, $urandom};
      bus.sout_wr_last = (i % 5 == 4);
      step();
    end
    bus.sout_wr_en = 1'b0;
    step();
    chk("ovf_full", bus.sout_buff_full, 1'b1);
    chk("ovf_sticky", bus.sout_overflow, 1'b1);
    cnt0 = xfer_cnt;
    drain("ovf_drain_q");
    step();
    chk("ovf_drain_count", xfer_cnt - cnt0, DEPTH + 1);
    chk("ovf_drain_empty", bus.sout_buff_empty, 1'b1);
    do_reset();

    // Random traffic across several pointer wraps.
    sent = 0;
    for (int c = 0; c < 4000 && sent < 3 * DEPTH; c++) begin
      bus.ostream_ready = 1'($urandom_range(0, 1));
      bus.sout_wr_en    = ($urandom_range(0, 3) != 0) && !bus.sout_buff_full;
      bus.sout_wr_data  = {$urandom, $urandom};
      bus.sout_wr_last  = ($urandom_range(0, 3) == 0);
      if (bus.sout_wr_en) sent++;
      step();
    end
    chk("wrap_sent", sent, 3 * DEPTH);
    drain("wrap_drain");
    chk("wrap_no_overflow", bus.sout_overflow, 1'b0);

    // Reset in the middle of a 4-word packet.
    bus.ostream_ready = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      bus.sout_wr_en   = 1'b1;
      bus.sout_wr_data = DW'(16'hB000 + i);
      bus.sout_wr_last = 1'b0;
      step();
    end
    do_reset();
    bus.ostream_ready = 1'b1;
    bus.sout_wr_en    = 1'b1;
    bus.sout_wr_data  = 64'h77;
    bus.sout_wr_last  = 1'b0;
    step();
    bus.sout_wr_en = 1'b0;
    step();
    chk("post_rst_data", bus.ostream_data, 64'h77);
    chk("post_rst_first", bus.ostream_first, 1'b1);
    drain("final_drain");

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sout_stream_buffer.md
SOUT_STREAM_BUFFER -- requirements
Module: sout_stream_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 64: width of each stream data word.
REQ-002 Parameter DEPTH, default 16: FIFO storage entries, power of two, minimum 4.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of ostream_clk.
REQ-004 ostream_clk  in  1  clock.
REQ-005 ostream_rst  in  1  synchronous active-high reset.
REQ-006 sout_wr_en  in  1  producer write strobe.
REQ-007 sout_wr_data  in  DATA_WIDTH  producer word.
REQ-008 sout_wr_last  in  1  word ends the current packet.
REQ-009 ostream_valid  out  1  output word valid.
REQ-010 ostream_data  out  DATA_WIDTH  output word.
REQ-011 ostream_first  out  1  first word of a packet.
REQ-012 ostream_last  out  1  last word of a packet.
REQ-013 ostream_ready  in  1  consumer accepts the word.
REQ-014 sout_buff_full  out  1  FIFO storage holds DEPTH entries.
REQ-015 sout_buff_empty  out  1  FIFO storage and output register both empty.
REQ-016 sout_overflow  out  1  sticky: a write was dropped.

Function
REQ-017 Each entry SHALL store {first, last, data}; first SHALL be 1 for the first write after reset and for the first write after a write with sout_wr_last=1, otherwise 0.
REQ-018 A write while sout_buff_full=1 SHALL be dropped even if a pop occurs in the same cycle, SHALL set sout_overflow, and SHALL NOT alter the first-tracking state.
REQ-019 The output stage SHALL be one register; it SHALL load from the FIFO head when it is empty or when ostream_valid && ostream_ready, and the FIFO holds at least one entry.
REQ-020 A transfer SHALL occur exactly on a cycle with ostream_valid=1 and ostream_ready=1.
REQ-021 While ostream_valid=1 and ostream_ready=0, ostream_data/first/last SHALL hold stable.
REQ-022 ostream_valid SHALL NOT depend combinationally on ostream_ready.
REQ-023 Latency: with everything empty, a word written in cycle N SHALL show ostream_valid=1 in cycle N+2; no bypass path.
REQ-024 Back-to-back: with ostream_ready held 1 and a continuous supply, one word SHALL transfer every cycle.
REQ-025 Simultaneous write and FIFO pop when not full SHALL leave the entry count unchanged.
REQ-026 Read and write pointers SHALL be log2(DEPTH)+1 bits; full/empty SHALL be derived from pointer equality plus the MSB; pointers SHALL wrap modulo 2*DEPTH.
REQ-027 sout_buff_full and sout_buff_empty SHALL be registered or pointer-derived, with no combinational path from any input.
REQ-028 Word order SHALL be preserved exactly; no word SHALL be duplicated or lost except as specified in REQ-018.

Reset
REQ-029 On reset: pointers=0, output register cleared, ostream_valid=0, ostream_data=0, ostream_first=0, ostream_last=0, sout_buff_full=0, sout_buff_empty=1, sout_overflow=0, first-tracking=1.
REQ-030 Reset asserted mid-packet SHALL discard all buffered words; the next write after reset SHALL carry first=1.
REQ-031 Writes during reset SHALL be ignored.

Structure
REQ-032 Package ostream_pkg SHALL hold the DATA_WIDTH default, the packed entry typedef {first, last, data}, and the DEPTH default.
REQ-033 Storage SHALL be the sub-module sout_fifo_mem (synchronous write, asynchronous-read register array); control and the output stage SHALL reside in sout_stream_buffer.

Verification
REQ-034 Single word: write 0xA5A5 with last=1, ready=1 -> valid in cycle N+2 with data 0xA5A5, first=1, last=1, then sout_buff_empty=1.
REQ-035 Backpressure: 3-word packet (0x1, 0x2, 0x3 last) with ready=0 for 5 cycles -> data 0x1 held stable, then 0x1/0x2/0x3 transfer on consecutive cycles with first only on 0x1 and last only on 0x3.
REQ-036 Full/overflow: ready=0, write DEPTH+2 words -> sout_buff_full=1, sout_overflow=1, and exactly DEPTH+1 words drain (DEPTH in the FIFO plus 1 in the output register), in order.
REQ-037 Wrap: stream 3*DEPTH words with random ready -> all words arrive in order and full/empty match the scoreboard.
REQ-038 Reset mid-packet after word 2 of 4 -> outputs at reset values; the next written word has first=1.
